controller_operator_stack: RTL
==============================

# controller_operator_stack

LIFO operator stack for the calculator controller: the storage end of the `op_data`/`op_empty` interface that the controller register blocks read. It holds `CO_N`-bit operator codes pushed by the controller during precedence resolution. It presents the registered top-of-stack and empty/full status, and services push, pop, replace and clear requests in one cycle. It sits beside the data stack and is driven directly by the controller's state-decoded strobes.

## Interface
Parameters:
- `AW`, default 3: pointer width; stack depth is 2**`AW` entries (default 8).

Ports:
- `Clock`  in  1  system clock; all state changes occur on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `op_push`  in  1  push `op_wdata` this cycle.
- `op_pop`  in  1  pop the top entry this cycle.
- `op_clear`  in  1  empty the stack; highest priority.
- `op_wdata`  in  `CO_N`  operator code to push.
- `op_data`  out  `CO_N`  registered top-of-stack; `CO_NO when empty.
- `op_empty`  out  1  count == 0.
- `op_full`  out  1  count == 2**`AW`.
- `op_count`  out  `AW`+1  number of valid entries.
- `op_err`  out  1  sticky overflow/underflow flag; present only with the macro below, otherwise tied 0.

## Operation
- Internal state: entry array `mem[0..2**AW-1]`, counter `cnt` (`AW`+1 bits) and top register `top_q`.
- Command priority, evaluated each edge:
  - clear: `cnt`←0, `top_q`←`CO_NO.
  - push+pop, `cnt`>0: replace top; `mem[cnt-1]`←`op_wdata`, `top_q`←`op_wdata`, `cnt` unchanged.
  - push+pop, `cnt`==0: treated as push only; pop is an underflow.
  - push, not full: `mem[cnt]`←`op_wdata`, `cnt`←`cnt`+1, `top_q`←`op_wdata`.
  - push, full: ignored; overflow. State unchanged; `top_q` holds.
  - pop, `cnt`>1: `cnt`←`cnt`-1, `top_q`←`mem[cnt-2]`.
  - pop, `cnt`==1: `cnt`←0, `top_q`←`CO_NO.
  - pop, `cnt`==0: ignored; underflow.
  - idle: hold.
- `op_empty`, `op_full` and `op_count` are decoded combinationally from `cnt` only; there is no combinational path from inputs to outputs.
- Replace at full is legal and is not an overflow.
- Array contents are never reset. Entries at or above `cnt` are don't-care and are never exposed.

## Timing
- All outputs reflect a command one cycle after the edge that samples it; there is no same-cycle bypass.
- Back-to-back commands every cycle are supported at full rate.
- `Reset` low, asynchronous: `cnt`=0, `op_data`=`CO_NO, `op_empty`=1, `op_full`=0, `op_count`=0, `op_err`=0. This takes effect immediately, including mid-sequence; no command is completed.
- The first command is accepted on the first rising edge after `Reset` deasserts.
- `op_clear` does not clear `op_err`; only `Reset` does.

## Configuration
- `CONT_OPSTACK_ERR_EN` defined:
  - `op_err` is set on the edge of any overflow or underflow.
  - It stays set until `Reset`.
  - It is held even while clear is asserted in the same cycle.
- `CONT_OPSTACK_ERR_EN` undefined:
  - No error register exists and `op_err` is constant 0.
  - Overflow and underflow are silently ignored, with the same state behaviour as above.

## Structure
- `CO_N` and `CO_NO come from the shared `CONT_INTERNAL.v` header. No new widths are defined locally.
- Add `CO_STACK_AW` (value 3) to `CONT_INTERNAL.v` so the controller and the stack agree on depth.
- One sub-module, `controller_operator_stack_mem`:
  - a 2**`AW` × `CO_N` register file;
  - one synchronous write port;
  - two asynchronous read ports, at `cnt-1` and `cnt-2`;
  - no reset.
- Pointer and count logic, the top register and the error flag stay in the top module.

## Test plan
- Reset then idle:
  - Response: `op_empty`=1, `op_count`=0, `op_data`=`CO_NO, `op_err`=0.
  - Pop while empty: state unchanged; `op_err`=1 only with the macro defined.
- Fill and drain:
  - Stimulus: push codes 1..8 on consecutive cycles.
  - Response: `op_full`=1, `op_count`=8, `op_data`=8.
  - Stimulus: eight pops.
  - Response: `op_data` steps 7,6,…,1, then `CO_NO with `op_empty`=1.
- Overflow:
  - Stimulus: at full, push 9.
  - Response: `op_count` stays 8, `op_data` stays 8, `op_err`=1 (macro defined) or 0 (undefined).
- Replace:
  - Stimulus: with stack [2,5], push+pop of 7.
  - Response: `op_count`=2, `op_data`=7. A following pop gives `op_data`=2.
  - Push+pop while empty, data 4: `op_count`=1, `op_data`=4, underflow flagged.
- Clear priority:
  - Stimulus: with 3 entries, assert clear+push+pop together.
  - Response: `op_count`=0, `op_data`=`CO_NO. A prior `op_err` is retained.
- Async reset mid-sequence:
  - Stimulus: drop `Reset` between edges while 5 entries are held.
  - Response: outputs go to reset values before the next edge.
  - After release, push 3: `op_count`=1, `op_data`=3.

Source files
------------

// File: rtl/controller_operator_stack_pkg.sv
// Shared definitions for the calculator controller operator stack.
// Mirrors the controller-wide constants: operator code width, the
// "no operator" code and the agreed stack depth, plus the decoded
// command type used internally by the stack.
package controller_operator_stack_pkg;

  // Operator code width and the code presented when no operator is held.
  localparam int              CO_N        = 4;
  localparam logic [CO_N-1:0] CO_NO       = '0;

  // Stack pointer width shared by the controller and the stack (depth 8).
  localparam int              CO_STACK_AW = 3;

  // One decoded action per edge, after priority resolution.
  typedef enum logic [2:0] {
    CMD_IDLE,      // hold, including ignored overflow/underflow requests
    CMD_CLEAR,     // empty the stack
    CMD_REPLACE,   // overwrite the top entry
    CMD_PUSH,      // add a new top entry
    CMD_POP,       // remove top, expose the entry below
    CMD_POP_LAST   // remove the only entry
  } op_cmd_e;

endpackage

// File: rtl/controller_operator_stack_mem.sv
// Register file behind the operator stack: 2**AW entries of DW bits,
// one synchronous write port and two asynchronous read ports (the top
// entry and the entry below it). Contents are not reset.
module controller_operator_stack_mem #(
  parameter int AW = 3,
  parameter int DW = 4
) (
  input  logic          Clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_top,
  input  logic [AW-1:0] raddr_below,
  output logic [DW-1:0] rdata_top,
  output logic [DW-1:0] rdata_below
);

  logic [DW-1:0] mem [2**AW];

  // Synchronous write of the pushed or replacing operator code.
  // NOTE: no reset on the array -- entries at or above the count are never
  // exposed, so clearing them would only cost a reset net on every bit.
  always_ff @(posedge Clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_top   = mem[raddr_top];
  assign rdata_below = mem[raddr_below];

endmodule

// File: rtl/controller_operator_stack.sv
// LIFO operator stack for the calculator controller. Presents a
// registered top-of-stack plus empty/full/count decoded from the entry
// counter, and services clear, replace, push and pop in one cycle with
// clear taking priority.
// Optional feature: define CONT_OPSTACK_ERR_EN to get a sticky
// overflow/underflow flag on op_err; otherwise op_err is tied low.
module controller_operator_stack
  import controller_operator_stack_pkg::*;
#(
  parameter int AW = CO_STACK_AW
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            op_push,
  input  logic            op_pop,
  input  logic            op_clear,
  input  logic [CO_N-1:0] op_wdata,
  output logic [CO_N-1:0] op_data,
  output logic            op_empty,
  output logic            op_full,
  output logic [AW:0]     op_count,
  output logic            op_err
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

  logic [AW:0]     cnt;
  logic [CO_N-1:0] top_q;
  op_cmd_e         cmd;

  logic            is_empty;
  logic            is_full;
  logic            is_one;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [AW-1:0]   addr_top;
  logic [AW-1:0]   addr_below;
  logic [CO_N-1:0] rd_top;
  logic [CO_N-1:0] rd_below;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == DEPTH);
  assign is_one   = (cnt == ONE);

  // Low pointer bits wrap correctly at full: 3'b000 - 1 addresses entry 7.
  assign addr_top   = cnt[AW-1:0] - AW'(1);
  assign addr_below = cnt[AW-1:0] - AW'(2);

  // Resolve the request strobes into a single action for this edge.
  // NOTE: cmd gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cmd = CMD_IDLE;
    if (op_clear) begin
      cmd = CMD_CLEAR;
    end else if (op_push && op_pop) begin
      cmd = is_empty ? CMD_PUSH : CMD_REPLACE;
    end else if (op_push) begin
      cmd = is_full ? CMD_IDLE : CMD_PUSH;
    end else if (op_pop) begin
      if (is_empty) begin
        cmd = CMD_IDLE;
      end else if (is_one) begin
        cmd = CMD_POP_LAST;
      end else begin
        cmd = CMD_POP;
      end
    end
  end

  assign mem_we    = (cmd == CMD_PUSH) || (cmd == CMD_REPLACE);
  assign mem_waddr = (cmd == CMD_REPLACE) ? addr_top : cnt[AW-1:0];

  controller_operator_stack_mem #(
    .AW (AW),
    .DW (CO_N)
  ) u_mem (
    .Clock       (Clock),
    .we          (mem_we),
    .waddr       (mem_waddr),
    .wdata       (op_wdata),
    .raddr_top   (addr_top),
    .raddr_below (addr_below),
    .rdata_top   (rd_top),
    .rdata_below (rd_below)
  );

  // Entry counter and registered top-of-stack.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      cnt   <= '0;
      top_q <= CO_NO;
    end else begin
      unique case (cmd)
        CMD_CLEAR: begin
          cnt   <= '0;
          top_q <= CO_NO;
        end
        CMD_REPLACE: begin
          top_q <= op_wdata;
        end
        CMD_PUSH: begin
          cnt   <= cnt + ONE;
          top_q <= op_wdata;
        end
        CMD_POP: begin
          cnt   <= cnt - ONE;
          top_q <= rd_below;
        end
        CMD_POP_LAST: begin
          cnt   <= '0;
          top_q <= CO_NO;
        end
        default: begin
          // Hold re-reads the array so top_q always tracks mem[cnt-1].
          top_q <= is_empty ? CO_NO : rd_top;
        end
      endcase
    end
  end

  assign op_data  = top_q;
  assign op_empty = is_empty;
  assign op_full  = is_full;
  assign op_count = cnt;

`ifdef CONT_OPSTACK_ERR_EN
  logic err_q;
  logic err_event;

  // Overflow: push alone at full. Underflow: any pop at empty, including
  // push+pop. Clear suppresses both since no push/pop is performed.
  always_comb begin
    err_event = 1'b0;
    if (!op_clear) begin
      err_event = (op_push && !op_pop && is_full) || (op_pop && is_empty);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      err_q <= 1'b0;
    end else if (err_event) begin
      err_q <= 1'b1;
    end
  end

  assign op_err = err_q;
`else
  assign op_err = 1'b0;
`endif

endmodule
